alarm_snooze_ctrl: RTL and testbench

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

---
 rtl/alarm_snooze_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_snooze_ctrl.sv
// Alarm clock controller: four programmable alarm slots, ring/snooze FSM,
// per-event snooze limit, and a ring-duration counter ticked by minute pulses.

// One alarm slot: a BCD HH:MM time plus an enable bit. The match output is
// combinational on the current (pre-write) contents, so a write landing on the
// same edge as a minute pulse only takes effect from the following minute.
module alarm_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_sel,
    input  logic [15:0] wr_time,
    input  logic        wr_ena,
    input  logic [15:0] cur_time,
    output logic        hit
);

    logic [15:0] time_q;
    logic        en_q;

    // Slot storage, cleared to a disabled 00:00 slot by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_q <= 16'h0000;
            en_q   <= 1'b0;
        end else if (wr_sel) begin
            time_q <= wr_time;
            en_q   <= wr_ena;
        end
    end

    // Pure equality compare; midnight wrap needs no special case
    always_comb hit = en_q && (time_q == cur_time);

endmodule

module alarm_snooze_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_min,
    input  logic [15:0] cur_time,
    input  logic        wr_en,
    input  logic [1:0]  wr_idx,
    input  logic [15:0] wr_time,
    input  logic        wr_ena,
    input  logic        off_Alarm,
    input  logic        snooze,
    input  logic [3:0]  dur_Alarm,
    output logic        Alarm,
    output logic [1:0]  active_slot,
    output logic [1:0]  state,
    output logic [2:0]  snooze_cnt
);

    localparam int         NUM_SLOTS = 4;
    localparam logic [3:0] SNZ_LOAD  = 4'(SNOOZE_MIN);
    localparam logic [2:0] MAX_CNT   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        ILLEGAL = 2'd3
    } st_t;

    st_t                  state_q, state_d;
    logic [3:0]           dur_q, dur_d;
    logic [3:0]           snz_q, snz_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [1:0]           slot_q, slot_d;
    logic                 alarm_q, alarm_d;

    logic [NUM_SLOTS-1:0] hit;
    logic                 any_hit;
    logic [1:0]           win_idx;
    logic                 kill;
    logic                 snz_ok;
    logic                 dur_expire;
    logic                 snz_expire;
    logic [3:0]           dur_load;

    // Slot array, one instance per alarm slot
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        alarm_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .wr_sel   (wr_en && (wr_idx == 2'(i))),
            .wr_time  (wr_time),
            .wr_ena   (wr_ena),
            .cur_time (cur_time),
            .hit      (hit[i])
        );
    end

    // Lowest-index matching slot wins; scan from the top so the lowest sticks
    always_comb begin
        any_hit = |hit;
        win_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = 2'(i);
        end
    end

    // Event qualifiers shared by next-state and datapath logic
    always_comb begin
        kill       = wr_en && !wr_ena && (wr_idx == slot_q);
        snz_ok     = snooze && (cnt_q < MAX_CNT);
        dur_expire = clk_min && (dur_q <= 4'd1);
        snz_expire = clk_min && (snz_q <= 4'd1);
        dur_load   = (dur_Alarm == 4'd0) ? 4'd1 : dur_Alarm;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dur_q   <= '0;
            snz_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            snz_q   <= snz_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            alarm_q <= alarm_d;
        end
    end

    // Next-state: cancel (off or disabling the owning slot) beats snooze,
    // which beats minute expiry; matches outside IDLE are simply dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clk_min && any_hit && !off_Alarm) state_d = RINGING;
            end
            RINGING: begin
                if (off_Alarm || kill) state_d = IDLE;
                else if (snz_ok)       state_d = SNOOZE;
                else if (dur_expire)   state_d = IDLE;
            end
            SNOOZE: begin
                if (off_Alarm || kill) state_d = IDLE;
                else if (snz_expire)   state_d = RINGING;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values, keyed on the transition being taken
    always_comb begin
        dur_d  = dur_q;
        snz_d  = snz_q;
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (state_d == IDLE) begin
            // Any entry to (or stay in) IDLE ends the event; active_slot is kept
            cnt_d = '0;
            if (state_q != IDLE) begin
                dur_d = '0;
                snz_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    slot_d = win_idx;
                    dur_d  = dur_load;
                    cnt_d  = '0;
                end
                RINGING: begin
                    if (state_d == SNOOZE) begin
                        cnt_d = cnt_q + 3'd1;
                        snz_d = SNZ_LOAD;
                    end else if (clk_min) begin
                        dur_d = dur_q - 4'd1;
                    end
                end
                SNOOZE: begin
                    if (state_d == RINGING) begin
                        dur_d = dur_load;
                        snz_d = '0;
                    end else if (clk_min) begin
                        snz_d = snz_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: Alarm is a register tracking RINGING, so reset drops it at once
    always_comb begin
        alarm_d     = (state_d == RINGING);
        Alarm       = alarm_q;
        state       = state_q;
        active_slot = slot_q;
        snooze_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl (SNOOZE_MIN=5, MAX_SNOOZE=3).
module tb_alarm_snooze_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_min;
    logic [15:0] cur_time;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [15:0] wr_time;
    logic        wr_ena;
    logic        off_Alarm;
    logic        snooze;
    logic [3:0]  dur_Alarm;
    logic        Alarm;
    logic [1:0]  active_slot;
    logic [1:0]  state;
    logic [2:0]  snooze_cnt;

    int checks = 0;
    int errs   = 0;

    alarm_snooze_ctrl #(.SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_min     (clk_min),
        .cur_time    (cur_time),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_time     (wr_time),
        .wr_ena      (wr_ena),
        .off_Alarm   (off_Alarm),
        .snooze      (snooze),
        .dur_Alarm   (dur_Alarm),
        .Alarm       (Alarm),
        .active_slot (active_slot),
        .state       (state),
        .snooze_cnt  (snooze_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic minute(input logic [15:0] t);
        cur_time = t;
        clk_min  = 1'b1;
        tick();
        clk_min  = 1'b0;
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [15:0] t, input logic ena);
        wr_en = 1'b1; wr_idx = idx; wr_time = t; wr_ena = ena;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic cancel();
        off_Alarm = 1'b1;
        tick();
        off_Alarm = 1'b0;
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clk_min = 0; cur_time = 16'h0000; wr_en = 0; wr_idx = 0;
        wr_time = 0; wr_ena = 0; off_Alarm = 0; snooze = 0; dur_Alarm = 4'd2;
        tick(); tick();
        checks++;
        if ({Alarm, state, active_slot, snooze_cnt} !== 8'h00) begin
            errs++;
            $display("FAIL reset_vals Alarm=%0b state=%0d slot=%0d cnt=%0d exp all 0",
                     Alarm, state, active_slot, snooze_cnt);
        end
        reset = 1'b1;
        tick();
        minute(16'h0000);  // slots reset to 00:00 but disabled
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL reset_slots_disabled Alarm=%0b exp 0", Alarm); end
    endtask

    task automatic test_basic();
        write_slot(2'd1, 16'h0730, 1'b1);
        dur_Alarm = 4'd2;
        minute(16'h0729);
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL basic_nomatch Alarm=%0b exp 0", Alarm); end
        minute(16'h0730);
        checks++;
        if ({Alarm, state, active_slot} !== {1'b1, 2'd1, 2'd1}) begin
            errs++; $display("FAIL basic_ring Alarm=%0b state=%0d slot=%0d exp 1/1/1", Alarm, state, active_slot);
        end
        minute(16'h0731);
        checks++;
        if (Alarm !== 1'b1) begin errs++; $display("FAIL basic_dur1 Alarm=%0b exp 1", Alarm); end
        minute(16'h0732);
        checks++;
        if ({Alarm, state} !== {1'b0, 2'd0}) begin
            errs++; $display("FAIL basic_expire Alarm=%0b state=%0d exp 0/0", Alarm, state);
        end
    endtask

    task automatic test_priority();
        write_slot(2'd0, 16'h0600, 1'b1);
        write_slot(2'd2, 16'h0600, 1'b1);
        minute(16'h0600);
        checks++;
        if ({Alarm, active_slot} !== {1'b1, 2'd0}) begin
            errs++; $display("FAIL prio_lowest Alarm=%0b slot=%0d exp 1/0", Alarm, active_slot);
        end
        cancel();
        write_slot(2'd0, 16'h0600, 1'b0);
        dur_Alarm = 4'd0;  // zero duration rings for one minute
        minute(16'h0600);
        checks++;
        if ({Alarm, active_slot} !== {1'b1, 2'd2}) begin
            errs++; $display("FAIL prio_slot2 Alarm=%0b slot=%0d exp 1/2", Alarm, active_slot);
        end
        minute(16'h0601);
        checks++;
        if ({Alarm, state} !== {1'b0, 2'd0}) begin
            errs++; $display("FAIL dur_zero Alarm=%0b state=%0d exp 0/0", Alarm, state);
        end
    endtask

    task automatic test_snooze();
        dur_Alarm = 4'd9;
        minute(16'h0730);
        for (int n = 1; n <= 3; n++) begin
            press_snooze();
            checks++;
            if ({state, snooze_cnt, Alarm} !== {2'd2, 3'(n), 1'b0}) begin
                errs++; $display("FAIL snooze_enter%0d state=%0d cnt=%0d Alarm=%0b exp 2/%0d/0",
                                 n, state, snooze_cnt, Alarm, n);
            end
            for (int m = 0; m < 4; m++) minute(16'h0731);
            checks++;
            if (state !== 2'd2) begin errs++; $display("FAIL snooze_hold%0d state=%0d exp 2", n, state); end
            minute(16'h0731);
            checks++;
            if ({state, Alarm} !== {2'd1, 1'b1}) begin
                errs++; $display("FAIL snooze_wake%0d state=%0d Alarm=%0b exp 1/1", n, state, Alarm);
            end
        end
        press_snooze();  // fourth snooze is over the limit
        checks++;
        if ({state, Alarm, snooze_cnt} !== {2'd1, 1'b1, 3'd3}) begin
            errs++; $display("FAIL snooze_limit state=%0d Alarm=%0b cnt=%0d exp 1/1/3", state, Alarm, snooze_cnt);
        end
        cancel();
        checks++;
        if ({state, snooze_cnt} !== {2'd0, 3'd0}) begin
            errs++; $display("FAIL snooze_off state=%0d cnt=%0d exp 0/0", state, snooze_cnt);
        end
    endtask

    task automatic test_off_snooze();
        minute(16'h0730);
        off_Alarm = 1'b1; snooze = 1'b1;
        tick();
        snooze = 1'b0;
        checks++;
        if ({state, snooze_cnt, Alarm} !== {2'd0, 3'd0, 1'b0}) begin
            errs++; $display("FAIL off_beats_snooze state=%0d cnt=%0d Alarm=%0b exp 0/0/0", state, snooze_cnt, Alarm);
        end
        minute(16'h0730);  // off still held in IDLE
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL off_suppress Alarm=%0b exp 0", Alarm); end
        off_Alarm = 1'b0;
    endtask

    task automatic test_disable();
        minute(16'h0730);
        press_snooze();
        write_slot(2'd1, 16'h0730, 1'b0);
        checks++;
        if ({state, snooze_cnt, active_slot} !== {2'd0, 3'd0, 2'd1}) begin
            errs++; $display("FAIL disable_kill state=%0d cnt=%0d slot=%0d exp 0/0/1", state, snooze_cnt, active_slot);
        end
        minute(16'h0730);
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL disable_noring Alarm=%0b exp 0", Alarm); end
    endtask

    task automatic test_enable_write();
        write_slot(2'd3, 16'h0900, 1'b1);
        minute(16'h0900);
        write_slot(2'd3, 16'h0900, 1'b1);
        checks++;
        if ({state, Alarm, active_slot} !== {2'd1, 1'b1, 2'd3}) begin
            errs++; $display("FAIL enwrite_keep state=%0d Alarm=%0b slot=%0d exp 1/1/3", state, Alarm, active_slot);
        end
        cancel();
    endtask

    task automatic test_coincident();
        write_slot(2'd2, 16'h0600, 1'b1);
        wr_en = 1'b1; wr_idx = 2'd2; wr_time = 16'h0600; wr_ena = 1'b0;
        minute(16'h0600);
        wr_en = 1'b0;
        checks++;
        if ({Alarm, active_slot} !== {1'b1, 2'd2}) begin
            errs++; $display("FAIL coinc_prewrite Alarm=%0b slot=%0d exp 1/2", Alarm, active_slot);
        end
        cancel();
        minute(16'h0600);
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL coinc_disabled Alarm=%0b exp 0", Alarm); end
        wr_en = 1'b1; wr_idx = 2'd3; wr_time = 16'h1000; wr_ena = 1'b1;
        minute(16'h1000);
        wr_en = 1'b0;
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL coinc_newtime_early Alarm=%0b exp 0", Alarm); end
        minute(16'h1000);
        checks++;
        if ({Alarm, active_slot} !== {1'b1, 2'd3}) begin
            errs++; $display("FAIL coinc_newtime Alarm=%0b slot=%0d exp 1/3", Alarm, active_slot);
        end
        cancel();
    endtask

    task automatic test_discard();
        write_slot(2'd0, 16'h1100, 1'b1);
        dur_Alarm = 4'd3;
        minute(16'h1000);
        minute(16'h1100);  // slot 0 matches mid-ring
        checks++;
        if ({state, active_slot} !== {2'd1, 2'd3}) begin
            errs++; $display("FAIL discard_ring state=%0d slot=%0d exp 1/3", state, active_slot);
        end
        cancel();
        tick();
        checks++;
        if (state !== 2'd0) begin errs++; $display("FAIL discard_noqueue state=%0d exp 0", state); end
    endtask

    task automatic test_wrap();
        write_slot(2'd0, 16'h0000, 1'b1);
        minute(16'h2359);
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL wrap_2359 Alarm=%0b exp 0", Alarm); end
        minute(16'h0000);
        checks++;
        if ({Alarm, active_slot} !== {1'b1, 2'd0}) begin
            errs++; $display("FAIL wrap_0000 Alarm=%0b slot=%0d exp 1/0", Alarm, active_slot);
        end
    endtask

    task automatic test_reset_mid();
        // Ringing on slot 0 from the previous test
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({Alarm, state} !== {1'b0, 2'd0}) begin
            errs++; $display("FAIL reset_async Alarm=%0b state=%0d exp 0/0", Alarm, state);
        end
        tick();
        reset = 1'b1;
        tick();
        minute(16'h0000);
        checks++;
        if ({Alarm, active_slot, snooze_cnt} !== {1'b0, 2'd0, 3'd0}) begin
            errs++; $display("FAIL reset_noresume Alarm=%0b slot=%0d cnt=%0d exp 0/0/0", Alarm, active_slot, snooze_cnt);
        end
        minute(16'h1000);
        checks++;
        if (Alarm !== 1'b0) begin errs++; $display("FAIL reset_slot3_cleared Alarm=%0b exp 0", Alarm); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_snooze();
        test_off_snooze();
        test_disable();
        test_enable_write();
        test_coincident();
        test_discard();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
